// File: rtl/pocket.sv
// Shared Pocket bridge types: address/data words and inclusive address windows.
package pocket;

  typedef logic [31:0] bridge_addr_t;
  typedef logic [31:0] bridge_data_t;

  typedef struct packed {
    bridge_addr_t from_addr;
    bridge_addr_t to_addr;
  } bridge_addr_range_t;

endpackage

// File: rtl/bridge_target_router_if.sv
// Bridge-side and target-side signals of bridge_target_router, bundled for port connection.
interface bridge_target_router_if #(
  parameter int unsigned N_TARGETS = 4
);

  pocket::bridge_addr_t      bridge_addr;
  logic                      bridge_wr;
  pocket::bridge_data_t      bridge_wr_data;
  logic                      bridge_rd;
  pocket::bridge_data_t      bridge_rd_data;
  pocket::bridge_addr_t      tgt_addr;
  pocket::bridge_data_t      tgt_wr_data;
  logic [N_TARGETS-1:0]      tgt_wr;
  logic [N_TARGETS-1:0]      tgt_rd;
  logic [32*N_TARGETS-1:0]   tgt_rd_data;
  logic [N_TARGETS-1:0]      tgt_rd_valid;
  logic                      rd_busy;
  logic                      err_unmapped;
  logic                      err_timeout;

  // Host bridge plus target models.
  modport master (
    output bridge_addr, bridge_wr, bridge_wr_data, bridge_rd, tgt_rd_data, tgt_rd_valid,
    input  bridge_rd_data, tgt_addr, tgt_wr_data, tgt_wr, tgt_rd, rd_busy, err_unmapped,
           err_timeout
  );

  // The router.
  modport slave (
    input  bridge_addr, bridge_wr, bridge_wr_data, bridge_rd, tgt_rd_data, tgt_rd_valid,
    output bridge_rd_data, tgt_addr, tgt_wr_data, tgt_wr, tgt_rd, rd_busy, err_unmapped,
           err_timeout
  );

endinterface

// File: rtl/bridge_target_router.sv
// Decodes bridge accesses onto N target windows: one-cycle write strobes, and reads sequenced
// through a WAIT state with bounded timeout, abort on a new read, and fixed fill values.
module bridge_target_router
  import pocket::*;
#(
  parameter int unsigned        N_TARGETS    = 4,
  parameter bridge_addr_range_t RANGES [N_TARGETS] = '{
    '{32'h0000_0000, 32'h0FFF_FFFF},
    '{32'h1000_0000, 32'h1FFF_FFFF},
    '{32'h2000_0000, 32'h2FFF_FFFF},
    '{32'h3000_0000, 32'h3FFF_FFFF}
  },
  parameter int unsigned        TIMEOUT      = 16,
  parameter bridge_data_t       TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  bridge_target_router_if.slave bridge_io
);

  localparam int unsigned SelW        = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1;
  localparam logic [7:0]  TimeoutLast = 8'(TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e               state_q, state_d;
  logic [SelW-1:0]      sel_q, sel_d;
  logic [7:0]           cnt_q, cnt_d;
  bridge_data_t         rd_data_q, rd_data_d;
  bridge_addr_t         addr_q, addr_d;
  bridge_data_t         wr_data_q, wr_data_d;
  logic [N_TARGETS-1:0] tgt_wr_q, tgt_wr_d;
  logic [N_TARGETS-1:0] tgt_rd_q, tgt_rd_d;
  logic                 err_unmapped_q, err_unmapped_d;
  logic                 err_timeout_q, err_timeout_d;

  logic                 hit;
  logic [SelW-1:0]      hit_idx;
  logic                 start_rd;

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = int'(N_TARGETS) - 1; i >= 0; i--) begin
      if (bridge_io.bridge_addr >= RANGES[i].from_addr &&
          bridge_io.bridge_addr <= RANGES[i].to_addr) begin
        hit     = 1'b1;
        hit_idx = SelW'(i);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    cnt_d          = cnt_q;
    rd_data_d      = rd_data_q;
    addr_d         = addr_q;
    wr_data_d      = wr_data_q;
    tgt_wr_d       = '0;
    tgt_rd_d       = '0;
    err_unmapped_d = 1'b0;
    err_timeout_d  = 1'b0;
    start_rd       = 1'b0;

    if (bridge_io.bridge_wr) begin
      if (hit) begin
        addr_d            = bridge_io.bridge_addr;
        wr_data_d         = bridge_io.bridge_wr_data;
        tgt_wr_d[hit_idx] = 1'b1;
      end else begin
        err_unmapped_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: start_rd = bridge_io.bridge_rd;
      StWait: begin
        if (bridge_io.bridge_rd) begin
          // Abort: the old read's data, even if valid this cycle, is dropped.
          err_timeout_d = 1'b1;
          start_rd      = 1'b1;
        end else if (bridge_io.tgt_rd_valid[sel_q]) begin
          rd_data_d = bridge_io.tgt_rd_data[{sel_q, 5'd0} +: 32];
          state_d   = StIdle;
        end else if (cnt_q == TimeoutLast) begin
          rd_data_d     = TIMEOUT_DATA;
          err_timeout_d = 1'b1;
          state_d       = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_rd) begin
      if (bridge_io.bridge_wr || !hit) begin
        // A colliding write owns tgt_addr; the read is dropped without touching read data.
        err_unmapped_d = 1'b1;
        state_d        = StIdle;
        if (!bridge_io.bridge_wr) rd_data_d = '0;
      end else begin
        addr_d            = bridge_io.bridge_addr;
        sel_d             = hit_idx;
        tgt_rd_d[hit_idx] = 1'b1;
        cnt_d             = '0;
        state_d           = StWait;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      sel_q          <= '0;
      cnt_q          <= '0;
      rd_data_q      <= '0;
      addr_q         <= '0;
      wr_data_q      <= '0;
      tgt_wr_q       <= '0;
      tgt_rd_q       <= '0;
      err_unmapped_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      cnt_q          <= cnt_d;
      rd_data_q      <= rd_data_d;
      addr_q         <= addr_d;
      wr_data_q      <= wr_data_d;
      tgt_wr_q       <= tgt_wr_d;
      tgt_rd_q       <= tgt_rd_d;
      err_unmapped_q <= err_unmapped_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  assign bridge_io.bridge_rd_data = rd_data_q;
  assign bridge_io.tgt_addr       = addr_q;
  assign bridge_io.tgt_wr_data    = wr_data_q;
  assign bridge_io.tgt_wr         = tgt_wr_q;
  assign bridge_io.tgt_rd         = tgt_rd_q;
  assign bridge_io.rd_busy        = (state_q == StWait);
  assign bridge_io.err_unmapped   = err_unmapped_q;
  assign bridge_io.err_timeout    = err_timeout_q;

endmodule

// File: tb/tb_bridge_target_router.sv
// Scoreboard bench for bridge_target_router: stimulus queues expected output events with their
// cycle numbers; per-DUT monitors pop and compare whenever a strobe, error or read completion shows.
module tb_bridge_target_router;
  import pocket::*;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  wr;
    logic [3:0]  rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        eu;
    logic        et;
    logic        busy;
  } obs_t;

  localparam bridge_addr_range_t RangesB [3] = '{
    '{32'h0000_0000, 32'h0000_FFFF},
    '{32'h0000_8000, 32'h0001_FFFF},
    '{32'h2000_0000, 32'h2FFF_FFFF}
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  obs_t  q_a[$], q_b[$];
  string nq_a[$], nq_b[$];
  logic  pb_a = 1'b0, pb_b = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bridge_target_router_if #(.N_TARGETS(4)) ba ();
  bridge_target_router_if #(.N_TARGETS(3)) bb ();

  bridge_target_router dut_a (
    .clk_i     (clk),
    .rst_i     (rst),
    .bridge_io (ba.slave)
  );

  bridge_target_router #(
    .N_TARGETS    (3),
    .RANGES       (RangesB),
    .TIMEOUT      (2),
    .TIMEOUT_DATA (32'h0BAD_F00D)
  ) dut_b (
    .clk_i     (clk),
    .rst_i     (rst),
    .bridge_io (bb.slave)
  );

  function automatic void show_fail(string n, obs_t a, obs_t e);
    $display("FAIL %s: got cyc=%0d wr=%b rd=%b addr=%h wd=%h rdata=%h eu=%b et=%b busy=%b; expected cyc=%0d wr=%b rd=%b addr=%h wd=%h rdata=%h eu=%b et=%b busy=%b",
             n, a.cyc, a.wr, a.rd, a.addr, a.wdata, a.rdata, a.eu, a.et, a.busy,
             e.cyc, e.wr, e.rd, e.addr, e.wdata, e.rdata, e.eu, e.et, e.busy);
  endfunction

  function automatic void cmp_obs(string n, obs_t e, obs_t a);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      show_fail(n, a, e);
    end
  endfunction

  function automatic void chk32(string n, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end
  endfunction

  function automatic void expect_ev(bit on_b, string n, int c, logic [3:0] wr, logic [3:0] rd,
                                    logic [31:0] addr, logic [31:0] wd, logic [31:0] rdata,
                                    logic eu, logic et, logic busy);
    obs_t e;
    e.cyc = 32'(c); e.wr = wr; e.rd = rd; e.addr = addr; e.wdata = wd; e.rdata = rdata;
    e.eu = eu; e.et = et; e.busy = busy;
    if (on_b) begin q_b.push_back(e); nq_b.push_back(n); end
    else      begin q_a.push_back(e); nq_a.push_back(n); end
  endfunction

  always @(negedge clk) begin : mon_a
    obs_t o;
    o.cyc = 32'(cyc); o.wr = ba.tgt_wr; o.rd = ba.tgt_rd; o.addr = ba.tgt_addr;
    o.wdata = ba.tgt_wr_data; o.rdata = ba.bridge_rd_data; o.eu = ba.err_unmapped;
    o.et = ba.err_timeout; o.busy = ba.rd_busy;
    if (|o.wr || |o.rd || o.eu || o.et || (pb_a && !o.busy)) begin
      if (q_a.size() == 0) begin
        n_cmp++; n_fail++;
        show_fail("dut_a_unexpected_event", o, '0);
      end else begin
        cmp_obs(nq_a.pop_front(), q_a.pop_front(), o);
      end
    end
    pb_a <= o.busy;
  end

  always @(negedge clk) begin : mon_b
    obs_t o;
    o.cyc = 32'(cyc); o.wr = {1'b0, bb.tgt_wr}; o.rd = {1'b0, bb.tgt_rd}; o.addr = bb.tgt_addr;
    o.wdata = bb.tgt_wr_data; o.rdata = bb.bridge_rd_data; o.eu = bb.err_unmapped;
    o.et = bb.err_timeout; o.busy = bb.rd_busy;
    if (|o.wr || |o.rd || o.eu || o.et || (pb_b && !o.busy)) begin
      if (q_b.size() == 0) begin
        n_cmp++; n_fail++;
        show_fail("dut_b_unexpected_event", o, '0);
      end else begin
        cmp_obs(nq_b.pop_front(), q_b.pop_front(), o);
      end
    end
    pb_b <= o.busy;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    ba.bridge_addr = '0; ba.bridge_wr = 1'b0; ba.bridge_wr_data = '0; ba.bridge_rd = 1'b0;
    ba.tgt_rd_data = '0; ba.tgt_rd_valid = '0;
    bb.bridge_addr = '0; bb.bridge_wr = 1'b0; bb.bridge_wr_data = '0; bb.bridge_rd = 1'b0;
    bb.tgt_rd_data = '0; bb.tgt_rd_valid = '0;
    rst = 1'b1;
    step(); step();
    chk32("reset_rd_data", ba.bridge_rd_data, 32'h0);
    chk32("reset_tgt_addr", ba.tgt_addr, 32'h0);
    chk32("reset_flags", 32'({ba.rd_busy, ba.err_unmapped, ba.err_timeout, ba.tgt_rd, ba.tgt_wr}),
          32'h0);
    rst = 1'b0;
    step();

    // Read target 1, valid in first WAIT cycle.
    c = cyc;
    ba.bridge_addr = 32'h1000_0004; ba.bridge_rd = 1'b1;
    expect_ev(0, "rd1_strobe", c + 1, 4'b0000, 4'b0010, 32'h1000_0004, 0, 0, 0, 0, 1);
    expect_ev(0, "rd1_data", c + 2, 4'b0000, 4'b0000, 32'h1000_0004, 0, 32'hCAFE_0001, 0, 0, 0);
    step();
    ba.bridge_rd = 1'b0; ba.tgt_rd_valid = 4'b0010; ba.tgt_rd_data[63:32] = 32'hCAFE_0001;
    step();
    ba.tgt_rd_valid = '0;
    step();

    // Read target 2 with no valid: timeout, with stray valids from other targets.
    c = cyc;
    ba.bridge_addr = 32'h2000_0000; ba.bridge_rd = 1'b1;
    expect_ev(0, "rd2_strobe", c + 1, 4'b0000, 4'b0100, 32'h2000_0000, 0, 32'hCAFE_0001, 0, 0, 1);
    expect_ev(0, "rd2_timeout", c + 17, 4'b0000, 4'b0000, 32'h2000_0000, 0, 32'hDEAD_BEEF,
              0, 1, 0);
    step();
    ba.bridge_rd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ba.tgt_rd_valid = (i == 3 || i == 10) ? 4'b1011 : 4'b0000;
      step();
    end
    ba.tgt_rd_valid = '0;

    // Write to target 3.
    c = cyc;
    ba.bridge_addr = 32'h3000_0010; ba.bridge_wr_data = 32'h1234_5678; ba.bridge_wr = 1'b1;
    expect_ev(0, "wr3", c + 1, 4'b1000, 4'b0000, 32'h3000_0010, 32'h1234_5678, 32'hDEAD_BEEF,
              0, 0, 0);
    step();
    ba.bridge_wr = 1'b0;
    step();

    // Write during a pending read to target 0.
    c = cyc;
    ba.bridge_addr = 32'h0000_0040; ba.bridge_rd = 1'b1;
    expect_ev(0, "rd0_strobe", c + 1, 4'b0000, 4'b0001, 32'h0000_0040, 32'h1234_5678,
              32'hDEAD_BEEF, 0, 0, 1);
    step();
    ba.bridge_rd = 1'b0;
    ba.bridge_addr = 32'h1000_0008; ba.bridge_wr_data = 32'hAAAA_5555; ba.bridge_wr = 1'b1;
    expect_ev(0, "wr_in_wait", c + 2, 4'b0010, 4'b0000, 32'h1000_0008, 32'hAAAA_5555,
              32'hDEAD_BEEF, 0, 0, 1);
    step();
    ba.bridge_wr = 1'b0; ba.tgt_rd_valid = 4'b0001; ba.tgt_rd_data[31:0] = 32'h0000_0C0C;
    expect_ev(0, "rd0_data", c + 3, 4'b0000, 4'b0000, 32'h1000_0008, 32'hAAAA_5555,
              32'h0000_0C0C, 0, 0, 0);
    step();
    ba.tgt_rd_valid = '0;
    step();

    // Abort in third WAIT cycle while the old target answers.
    c = cyc;
    ba.bridge_addr = 32'h0000_0100; ba.bridge_rd = 1'b1;
    expect_ev(0, "abort_first", c + 1, 4'b0000, 4'b0001, 32'h0000_0100, 32'hAAAA_5555,
              32'h0000_0C0C, 0, 0, 1);
    step();
    ba.bridge_rd = 1'b0;
    step(); step();
    ba.bridge_addr = 32'h1000_0200; ba.bridge_rd = 1'b1;
    ba.tgt_rd_valid = 4'b0001; ba.tgt_rd_data[31:0] = 32'h0BAD_0BAD;
    expect_ev(0, "abort_second", c + 4, 4'b0000, 4'b0010, 32'h1000_0200, 32'hAAAA_5555,
              32'h0000_0C0C, 0, 1, 1);
    step();
    ba.bridge_rd = 1'b0; ba.tgt_rd_valid = 4'b0010; ba.tgt_rd_data[63:32] = 32'h600D_0001;
    expect_ev(0, "abort_data", c + 5, 4'b0000, 4'b0000, 32'h1000_0200, 32'hAAAA_5555,
              32'h600D_0001, 0, 0, 0);
    step();
    ba.tgt_rd_valid = '0;
    step();

    // Reset in the middle of WAIT.
    c = cyc;
    ba.bridge_addr = 32'h3000_0000; ba.bridge_rd = 1'b1;
    expect_ev(0, "rst_rd_strobe", c + 1, 4'b0000, 4'b1000, 32'h3000_0000, 32'hAAAA_5555,
              32'h600D_0001, 0, 0, 1);
    step();
    ba.bridge_rd = 1'b0;
    step();
    expect_ev(0, "rst_mid_wait", c + 2, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk32("async_rst_rd_data", ba.bridge_rd_data, 32'h0);
    chk32("async_rst_tgt_addr", ba.tgt_addr, 32'h0);
    chk32("async_rst_flags",
          32'({ba.rd_busy, ba.err_unmapped, ba.err_timeout, ba.tgt_rd, ba.tgt_wr}), 32'h0);
    step();
    rst = 1'b0;
    step();
    ba.tgt_rd_valid = 4'b1111; ba.tgt_rd_data = '1;
    step();
    ba.tgt_rd_valid = '0; ba.tgt_rd_data = '0;
    step();
    c = cyc;
    ba.bridge_addr = 32'h1000_0000; ba.bridge_rd = 1'b1;
    expect_ev(0, "post_rst_strobe", c + 1, 4'b0000, 4'b0010, 32'h1000_0000, 0, 0, 0, 0, 1);
    step();
    ba.bridge_rd = 1'b0; ba.tgt_rd_valid = 4'b0010; ba.tgt_rd_data[63:32] = 32'h1111_2222;
    expect_ev(0, "post_rst_data", c + 2, 4'b0000, 4'b0000, 32'h1000_0000, 0, 32'h1111_2222,
              0, 0, 0);
    step();
    ba.tgt_rd_valid = '0;
    step();

    // Simultaneous write and read: write wins, read flagged unmapped.
    c = cyc;
    ba.bridge_addr = 32'h0000_0050; ba.bridge_wr_data = 32'h0000_0005;
    ba.bridge_wr = 1'b1; ba.bridge_rd = 1'b1;
    expect_ev(0, "wr_rd_collide", c + 1, 4'b0001, 4'b0000, 32'h0000_0050, 32'h0000_0005,
              32'h1111_2222, 1, 0, 0);
    step();
    ba.bridge_wr = 1'b0; ba.bridge_rd = 1'b0;
    step();

    // DUT B: overlap, lowest index wins; TIMEOUT = 2.
    c = cyc;
    bb.bridge_addr = 32'h0000_8000; bb.bridge_rd = 1'b1;
    expect_ev(1, "b_overlap_strobe", c + 1, 4'b0000, 4'b0001, 32'h0000_8000, 0, 0, 0, 0, 1);
    expect_ev(1, "b_timeout", c + 3, 4'b0000, 4'b0000, 32'h0000_8000, 0, 32'h0BAD_F00D,
              0, 1, 0);
    step();
    bb.bridge_rd = 1'b0;
    step(); step(); step();

    c = cyc;
    bb.bridge_addr = 32'hF000_0000; bb.bridge_rd = 1'b1;
    expect_ev(1, "b_unmapped_rd", c + 1, 4'b0000, 4'b0000, 32'h0000_8000, 0, 0, 1, 0, 0);
    step();
    bb.bridge_rd = 1'b0;
    step();

    c = cyc;
    bb.bridge_addr = 32'h0001_0000; bb.bridge_wr_data = 32'h0000_0077; bb.bridge_wr = 1'b1;
    expect_ev(1, "b_wr_tgt1", c + 1, 4'b0010, 4'b0000, 32'h0001_0000, 32'h0000_0077, 0,
              0, 0, 0);
    step();
    bb.bridge_wr = 1'b0;
    repeat (3) step();

    chk32("dut_a_events_left", 32'(q_a.size()), 32'h0);
    chk32("dut_b_events_left", 32'(q_b.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bridge_target_router.md
# bridge_target_router

Routes the Pocket host bridge to N target blocks. Each target owns one address window, given as a `pocket::bridge_addr_range_t`. The router decodes every bridge access and forwards writes as one-cycle strobes. It sequences reads through a small wait state machine, with a bounded timeout and defined fill values for unmapped or unresponsive accesses. It sits between the top-level bridge signals and all bridge-mapped registers and memories, and is the only driver of `bridge_rd_data`.

## Interface
- `N_TARGETS`, default 4: number of targets, legal range 1..16.
- `RANGES`, default window i = `32'h1000_0000*i` .. `32'h1000_0000*i + 32'h0FFF_FFFF`: unpacked array `[N_TARGETS]` of `pocket::bridge_addr_range_t`. Both bounds are inclusive.
- `TIMEOUT`, default 16: maximum number of WAIT cycles for a read, legal range 2..255.
- `TIMEOUT_DATA`, default `32'hDEAD_BEEF`: value returned when a read times out.
- `clk`  in  1  bridge clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `bridge_addr`  in  32  `pocket::bridge_addr_t`.
- `bridge_wr`  in  1  write strobe, one cycle per access.
- `bridge_wr_data`  in  32  `pocket::bridge_data_t`.
- `bridge_rd`  in  1  read strobe, one cycle per access.
- `bridge_rd_data`  out  32  registered read result; held until the next read completes.
- `tgt_addr`  out  32  registered address forwarded to all targets.
- `tgt_wr_data`  out  32  registered write data forwarded to all targets.
- `tgt_wr`  out  N_TARGETS  one-hot write strobes.
- `tgt_rd`  out  N_TARGETS  one-hot read strobes.
- `tgt_rd_data`  in  32*N_TARGETS  read data; target i drives slice `[32*i +: 32]`.
- `tgt_rd_valid`  in  N_TARGETS  target i presents read data on the cycle it asserts its bit.
- `rd_busy`  out  1  high while the FSM is in WAIT.
- `err_unmapped`  out  1  one-cycle pulse: an access matched no window.
- `err_timeout`  out  1  one-cycle pulse: a read timed out or was aborted.

## Operation
- Decode: a target matches when `from_addr <= bridge_addr <= to_addr`. If windows overlap, the lowest index wins.
- Write path: on `bridge_wr` to target i, the router registers `tgt_addr` and `tgt_wr_data` and drives `tgt_wr[i]` for exactly one cycle. Writes are independent of the read FSM and are accepted in any state.
- Unmapped access, read or write: no target strobe is issued and `err_unmapped` pulses. An unmapped read loads `bridge_rd_data` with 0 and stays in IDLE.
- Read FSM, IDLE state: on `bridge_rd` to target i:
  - register `tgt_addr`;
  - latch `sel = i`;
  - pulse `tgt_rd[i]`;
  - clear `cnt` to 0;
  - go to WAIT.
- Read FSM, WAIT state:
  - If `tgt_rd_valid[sel]`: load `bridge_rd_data` from slice `sel`, go to IDLE.
  - Else if `cnt == TIMEOUT-1`: load `TIMEOUT_DATA`, pulse `err_timeout`, go to IDLE.
  - Else: `cnt <= cnt + 1`.
- `tgt_rd_valid` bits from targets other than `sel` are ignored in every state, including all of IDLE.
- New `bridge_rd` during WAIT:
  - The current read is aborted: `bridge_rd_data` is unchanged and `err_timeout` pulses.
  - The new read is then handled exactly as from IDLE: re-decode, new strobe, `cnt` reset to 0.
  - A `tgt_rd_valid[sel]` for the old read in that same cycle is discarded.
- Simultaneous `bridge_wr` and `bridge_rd` in one cycle: the write wins `tgt_addr`. The read is treated as unmapped-like: no strobe, `err_unmapped` pulses, `bridge_rd_data` is unchanged. The bridge never issues this combination; the rule only makes the behaviour deterministic.
- `cnt` is 8 bits wide and never wraps, because it is bounded by `TIMEOUT-1`.

## Timing
- Reset values: every output is 0 (`bridge_rd_data`, `tgt_*`, `rd_busy`, `err_*`), the FSM is in IDLE, `sel` = 0, `cnt` = 0. A reset asserted mid-WAIT returns to IDLE immediately, with no strobe and no error pulse.
- Write: `bridge_wr` sampled at edge k drives `tgt_wr[i]`, `tgt_addr` and `tgt_wr_data` in cycle k+1, for one cycle only.
- Read: `bridge_rd` sampled at edge k drives `tgt_rd[i]` and `rd_busy` in cycle k+1, which is the first WAIT cycle.
  - Valid is accepted in any WAIT cycle, including the first.
  - Valid in WAIT cycle m updates `bridge_rd_data` and drops `rd_busy` at the following edge.
  - Minimum latency is 2 cycles from `bridge_rd` to updated data.
- Timeout: with no valid, `rd_busy` stays high for exactly `TIMEOUT` cycles. `TIMEOUT_DATA` and `err_timeout` appear together in the cycle after the last WAIT cycle.
- Error pulses are registered and last exactly one cycle.

## Test plan
- Read `32'h1000_0004`; target 1 asserts valid in the first WAIT cycle with `32'hCAFE_0001` -> `tgt_rd = 4'b0010` for one cycle; `bridge_rd_data = 32'hCAFE_0001` 2 cycles after `bridge_rd`; `rd_busy` high for 1 cycle.
- Read target 2 and never assert valid, `TIMEOUT` = 16 -> `rd_busy` high for 16 cycles, then `bridge_rd_data = 32'hDEAD_BEEF` and `err_timeout` pulses once.
- Write `32'h3000_0010` with data `32'h1234_5678` -> `tgt_wr = 4'b1000` for one cycle, with `tgt_addr` and `tgt_wr_data` matching. A write issued during a pending read to target 0 leaves the read unaffected.
- `RANGES` overlapping on target 0 (`0..FFFF`) and target 1 (`8000..1_FFFF`); read `32'h8000` -> only `tgt_rd[0]` strobes. Read `32'hF000_0000` with only 3 targets configured -> `err_unmapped`, `bridge_rd_data = 0`, no strobe.
- Read target 0, then a second `bridge_rd` to target 1 in the third WAIT cycle while target 0 asserts valid -> `err_timeout` pulses, target 0's data is discarded, `tgt_rd[1]` strobes, and target 1's data is returned.
- Assert `reset` in the middle of WAIT -> all outputs are 0 asynchronously. A later read operates normally, and a stray `tgt_rd_valid` pulse while IDLE has no effect.
